// File: rtl/ts_scan_pkg.sv
// Shared types for the multichannel time-surface scanner:
// decay modes, scan FSM states and the fine-exponential table.
package ts_scan_pkg;

    typedef enum logic [1:0] {
        DM_EXP  = 2'd0,
        DM_LIN  = 2'd1,
        DM_FINE = 2'd2
    } decay_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    // Mode code 3 is folded onto plain exponential decay.
    function automatic decay_mode_e to_mode(input logic [1:0] m);
        case (m)
            2'd1:    return DM_LIN;
            2'd2:    return DM_FINE;
            default: return DM_EXP;
        endcase
    endfunction

    // max_v * 2^(-f/4), rounded down; 2^(-f/4) held in Q16.
    function automatic int fine_lut(input int max_v, input logic [1:0] f);
        case (f)
            2'd1:    return (max_v * 55109) >>> 16;
            2'd2:    return (max_v * 46341) >>> 16;
            2'd3:    return (max_v * 38968) >>> 16;
            default: return max_v;
        endcase
    endfunction

endpackage

// File: rtl/multichannel_time_surface_scanner_if.sv
// Output stream of the surface scanner (valid/ready).
// master: out_valid/out_value/out_cell/out_ch/out_last out, out_ready in.
interface multichannel_time_surface_scanner_if #(
    parameter int VALUE_BITS = 8,
    parameter int CELL_BITS  = 8,
    parameter int CH_BITS    = 1
);
    logic                  out_valid;
    logic                  out_ready;
    logic [VALUE_BITS-1:0] out_value;
    logic [CELL_BITS-1:0]  out_cell;
    logic [CH_BITS-1:0]    out_ch;
    logic                  out_last;

    modport master (
        output out_valid, out_value, out_cell, out_ch, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_value, out_cell, out_ch, out_last,
        output out_ready
    );
endinterface

// File: rtl/ts_decay_unit.sv
// Age-to-value decay (exp / linear / fine exp) plus one register stage.
// Ports: clk, rst, en (stage enable), mode, shift, t_snap, ts, cell_valid -> value.
module ts_decay_unit
    import ts_scan_pkg::*;
#(
    parameter int TS_BITS    = 16,
    parameter int VALUE_BITS = 8,
    parameter int MAX_VALUE  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  decay_mode_e           mode,
    input  logic [3:0]            shift,
    input  logic [TS_BITS-1:0]    t_snap,
    input  logic [TS_BITS-1:0]    ts,
    input  logic                  cell_valid,
    output logic [VALUE_BITS-1:0] value
);
    localparam logic [TS_BITS-1:0]    MAX_T = TS_BITS'(MAX_VALUE);
    localparam logic [TS_BITS-1:0]    NB    = TS_BITS'(VALUE_BITS);
    localparam logic [VALUE_BITS-1:0] MAX_V = VALUE_BITS'(MAX_VALUE);

    logic [TS_BITS-1:0]    dt;
    logic [TS_BITS-1:0]    q;
    logic [TS_BITS-1:0]    n;
    logic [3:0]            s;
    logic [VALUE_BITS-1:0] base;
    logic [VALUE_BITS-1:0] v_d;

    always_comb begin
        dt   = t_snap - ts;
        q    = dt >> shift;
        n    = q;
        s    = 4'd0;
        base = MAX_V;
        v_d  = '0;
        case (mode)
            DM_LIN: begin
                v_d = (q >= MAX_T) ? '0 : VALUE_BITS'(MAX_T - q);
            end
            DM_FINE: begin
                s    = (shift < 4'd2) ? 4'd0 : shift - 4'd2;
                q    = dt >> s;
                n    = q >> 2;
                base = VALUE_BITS'(fine_lut(MAX_VALUE, q[1:0]));
                v_d  = (n >= NB) ? '0 : base >> n;
            end
            default: begin
                v_d = (n >= NB) ? '0 : MAX_V >> n;
            end
        endcase
        // Ages past half the timestamp range may be wrapped aliases.
        if (!cell_valid || dt[TS_BITS-1]) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (en) begin
            value <= v_d;
        end
    end
endmodule

// File: rtl/multichannel_time_surface_scanner.sv
// Per-cell, per-polarity last-event timestamp store with a scan engine
// streaming the decayed surface. Ports: clk, rst, t_now, cfg_mode,
// cfg_shift, event_* (write), clear, scan_start/busy/done, out_if (stream).
module multichannel_time_surface_scanner
    import ts_scan_pkg::*;
#(
    parameter int GRID_SIZE  = 16,
    parameter int NUM_CH     = 2,
    parameter int TS_BITS    = 16,
    parameter int VALUE_BITS = 8,
    parameter int MAX_VALUE  = 255,
    parameter int CELL_BITS  = $clog2(GRID_SIZE * GRID_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [TS_BITS-1:0]           t_now,
    input  logic [1:0]                   cfg_mode,
    input  logic [3:0]                   cfg_shift,
    input  logic                         event_valid,
    input  logic [$clog2(GRID_SIZE)-1:0] event_x,
    input  logic [$clog2(GRID_SIZE)-1:0] event_y,
    input  logic                         event_pol,
    input  logic [TS_BITS-1:0]           event_ts,
    input  logic                         clear,
    input  logic                         scan_start,
    output logic                         scan_busy,
    output logic                         scan_done,
    multichannel_time_surface_scanner_if.master out_if
);
    localparam int DEPTH    = GRID_SIZE * GRID_SIZE * NUM_CH;
    localparam int IDX_BITS = $clog2(DEPTH);
    localparam int CH_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(DEPTH - 1);

    scan_state_e          state;
    scan_state_e          state_d;
    logic [IDX_BITS-1:0]  rd_idx;
    logic [IDX_BITS-1:0]  w_idx;
    logic [TS_BITS-1:0]   t_snap;
    decay_mode_e          mode_q;
    logic [3:0]           shift_q;
    logic                 stall;
    logic                 issue;
    logic                 acc_last;
    logic                 done_d;

    logic [TS_BITS-1:0]   ts_mem [DEPTH];
    logic [DEPTH-1:0]     vbits;
    logic [TS_BITS-1:0]   ram_q;
    logic                 vq;
    logic                 v1;
    logic                 v2;
    logic [IDX_BITS-1:0]  idx1;
    logic [IDX_BITS-1:0]  idx2;
    logic [VALUE_BITS-1:0] val2;

    // A held beat freezes every stage, including read issue.
    assign stall     = out_if.out_valid && !out_if.out_ready;
    assign issue     = (state == RUN) && !stall;
    assign acc_last  = out_if.out_valid && out_if.out_ready && out_if.out_last;
    assign scan_busy = (state != IDLE);

    always_comb begin
        w_idx = IDX_BITS'((int'(event_y) * GRID_SIZE + int'(event_x)) * NUM_CH
                + ((NUM_CH > 1) ? int'(event_pol) : 0));
    end

    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        unique case (state)
            IDLE:    if (scan_start) state_d = RUN;
            RUN:     if (issue && rd_idx == LAST) state_d = DRAIN;
            DRAIN: begin
                if (acc_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_idx    <= '0;
            t_snap    <= '0;
            mode_q    <= DM_EXP;
            shift_q   <= '0;
            scan_done <= 1'b0;
        end else begin
            state     <= state_d;
            scan_done <= done_d;
            if (state == IDLE && scan_start) begin
                t_snap  <= t_now;
                mode_q  <= to_mode(cfg_mode);
                shift_q <= cfg_shift;
                rd_idx  <= '0;
            end else if (issue) begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    // Non-blocking read and write in one process give read-first ordering.
    always_ff @(posedge clk) begin
        if (event_valid) ts_mem[w_idx] <= event_ts;
        if (issue) ram_q <= ts_mem[rd_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vbits <= '0;
            vq    <= 1'b0;
            v1    <= 1'b0;
            idx1  <= '0;
        end else begin
            if (clear) vbits <= '0;
            if (event_valid) vbits[w_idx] <= 1'b1;
            if (!stall) v1 <= (state == RUN);
            if (issue) begin
                vq   <= vbits[rd_idx];
                idx1 <= rd_idx;
            end
        end
    end

    ts_decay_unit #(
        .TS_BITS    (TS_BITS),
        .VALUE_BITS (VALUE_BITS),
        .MAX_VALUE  (MAX_VALUE)
    ) u_decay (
        .clk        (clk),
        .rst        (rst),
        .en         (!stall && v1),
        .mode       (mode_q),
        .shift      (shift_q),
        .t_snap     (t_snap),
        .ts         (ram_q),
        .cell_valid (vq),
        .value      (val2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2               <= 1'b0;
            idx2             <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_value <= '0;
            out_if.out_cell  <= '0;
            out_if.out_ch    <= '0;
            out_if.out_last  <= 1'b0;
        end else if (!stall) begin
            v2               <= v1;
            out_if.out_valid <= v2;
            out_if.out_last  <= v2 && (idx2 == LAST);
            if (v1) idx2 <= idx1;
            if (v2) begin
                out_if.out_value <= val2;
                out_if.out_cell  <= CELL_BITS'(int'(idx2) / NUM_CH);
                out_if.out_ch    <= CH_BITS'(int'(idx2) % NUM_CH);
            end
        end
    end
endmodule
